up_counter_seq_ctrl: RTL and testbench



---
 rtl/up_counter_seq_pkg.sv | 21 ++
 rtl/up_counter_core.sv | 30 +++
 rtl/up_counter_seq_ctrl.sv | 144 ++++++++++++++
 tb/tb_up_counter_seq_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/up_counter_seq_pkg.sv
// up_counter_seq_pkg: shared types for the up-counter sweep sequencer.
// Holds the FSM state enum, default widths and the sweep descriptor.
package up_counter_seq_pkg;

    localparam int CNT_W  = 5;
    localparam int REPS_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } seq_state_e;

    typedef struct packed {
        logic [CNT_W-1:0]  start;
        logic [CNT_W-1:0]  end_;
        logic [REPS_W-1:0] reps;
    } seq_desc_t;

endpackage

// File: rtl/up_counter_core.sv
// up_counter_core: WIDTH-bit up-counter, sync reset/load/enable.
// Ports: clk, reset, load+load_val, en, end_val -> cnt, eq_end.
module up_counter_core
    import up_counter_seq_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic [WIDTH-1:0] end_val,
    output logic [WIDTH-1:0] cnt,
    output logic             eq_end
);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

    assign eq_end = (cnt == end_val);

endmodule

// File: rtl/up_counter_seq_ctrl.sv
// up_counter_seq_ctrl: sweep sequencer driving up_counter_core.
// Ports: cfg_* descriptor handshake, pause, abort -> cnt_out,
// cnt_valid, busy, done, aborted. Optional UP_CNT_SEQ_PASS_IDX_EN
// adds pass_idx (0-based index of the current pass).
module up_counter_seq_ctrl
    import up_counter_seq_pkg::*;
#(
    parameter int WIDTH = CNT_W,
    parameter int REP_W = REPS_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_start,
    input  logic [WIDTH-1:0] cfg_end,
    input  logic [REP_W-1:0] cfg_reps,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] cnt_out,
    output logic             cnt_valid,
    output logic             busy,
    output logic             done,
`ifdef UP_CNT_SEQ_PASS_IDX_EN
    output logic [REP_W-1:0] pass_idx,
`endif
    output logic             aborted
);

    seq_state_e       state_q;
    seq_state_e       state_d;
    seq_desc_t        desc_q;
    logic [REP_W-1:0] rep_left_q;
    logic             aborted_q;

    logic accept;
    logic init;
    logic reload;
    logic ab_evt;
    logic ld;
    logic en;
    logic eq_end;

    up_counter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (ld),
        .load_val (desc_q.start),
        .en       (en),
        .end_val  (desc_q.end_),
        .cnt      (cnt_out),
        .eq_end   (eq_end)
    );

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        init    = 1'b0;
        reload  = 1'b0;
        ab_evt  = 1'b0;
        en      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    accept  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    ab_evt  = 1'b1;
                    state_d = IDLE;
                end else begin
                    init    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                // abort outranks pause and terminal count
                if (abort) begin
                    ab_evt  = 1'b1;
                    state_d = IDLE;
                end else if (!pause) begin
                    if (!eq_end) begin
                        en = 1'b1;
                    end else if (rep_left_q != '0) begin
                        reload = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ld = init | reload;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            desc_q     <= '0;
            rep_left_q <= '0;
            aborted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            aborted_q <= ab_evt;
            if (accept) begin
                desc_q.start <= cfg_start;
                desc_q.end_  <= cfg_end;
                desc_q.reps  <= cfg_reps;
            end
            if (init) begin
                rep_left_q <= desc_q.reps;
            end else if (reload) begin
                rep_left_q <= rep_left_q - REP_W'(1);
            end
        end
    end

`ifdef UP_CNT_SEQ_PASS_IDX_EN
    always_ff @(posedge clk) begin
        if (reset || init) begin
            pass_idx <= '0;
        end else if (reload) begin
            pass_idx <= pass_idx + REP_W'(1);
        end
    end
`endif

    assign cfg_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign cnt_valid = (state_q == RUN) && !pause && !abort;
    assign aborted   = aborted_q;

endmodule

// File: tb/tb_up_counter_seq_ctrl.sv
// tb_up_counter_seq_ctrl: table, hand-written and random sweeps
// checked against an arithmetic model of the sample stream.
module tb_up_counter_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [4:0] cfg_start;
    logic [4:0] cfg_end;
    logic [3:0] cfg_reps;
    logic       pause;
    logic       abort;
    logic [4:0] cnt_out;
    logic       cnt_valid;
    logic       busy;
    logic       done;
    logic       aborted;
`ifdef UP_CNT_SEQ_PASS_IDX_EN
    logic [3:0] pass_idx;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    up_counter_seq_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_start (cfg_start),
        .cfg_end   (cfg_end),
        .cfg_reps  (cfg_reps),
        .pause     (pause),
        .abort     (abort),
        .cnt_out   (cnt_out),
        .cnt_valid (cnt_valid),
        .busy      (busy),
        .done      (done),
`ifdef UP_CNT_SEQ_PASS_IDX_EN
        .pass_idx  (pass_idx),
`endif
        .aborted   (aborted)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Full descriptor: offer, LOAD, sample stream, DONE, back to IDLE.
    // noise drives abort/pause in IDLE, LOAD and DONE, where they
    // must have no effect.
    task automatic sweep(
        input  logic [4:0] s,
        input  logic [4:0] e,
        input  logic [3:0] r,
        input  bit         rnd_pause,
        input  int         pause_at,
        input  int         pause_len,
        input  bit         noise,
        output int         nval,
        output int         last
    );
        int len;
        int total;
        int idx;
        int guard;
        int held;
        int expv;
        len   = (int'(e) - int'(s) + 32) % 32 + 1;
        total = (int'(r) + 1) * len;
        idx   = 0;
        guard = 0;
        held  = 0;
        nval  = 0;
        last  = -1;
        step();
        cfg_valid = 1'b1;
        cfg_start = s;
        cfg_end   = e;
        cfg_reps  = r;
        abort     = noise;
        #1;
        chk("idle_ready", int'(cfg_ready), 1);
        chk("idle_busy", int'(busy), 0);
        step();
        cfg_valid = 1'b0;
        abort     = 1'b0;
        pause     = noise;
        #1;
        chk("load_busy", int'(busy), 1);
        chk("load_ready", int'(cfg_ready), 0);
        chk("load_valid", int'(cnt_valid), 0);
        chk("load_aborted", int'(aborted), 0);
        while (idx < total && guard < 4000) begin
            step();
            guard++;
            expv = (int'(s) + idx % len) % 32;
            if (rnd_pause) begin
                pause = ($urandom_range(0, 3) == 0);
            end else begin
                pause = (expv == pause_at) && (held < pause_len);
                if (pause) held++;
            end
            #1;
            chk("run_valid", int'(cnt_valid), int'(!pause));
            chk("run_cnt", int'(cnt_out), expv);
            chk("run_done", int'(done), 0);
            chk("run_busy", int'(busy), 1);
`ifdef UP_CNT_SEQ_PASS_IDX_EN
            chk("run_pass_idx", int'(pass_idx), idx / len);
`endif
            if (cnt_valid) begin
                nval++;
                last = int'(cnt_out);
            end
            if (!pause) idx++;
        end
        if (guard >= 4000) chk("run_timeout", guard, 0);
        step();
        pause = noise;
        abort = noise;
        #1;
        chk("done_pulse", int'(done), 1);
        chk("done_busy", int'(busy), 1);
        chk("done_cnt", int'(cnt_out), int'(e));
        chk("done_valid", int'(cnt_valid), 0);
        step();
        pause = 1'b0;
        abort = 1'b0;
        #1;
        chk("post_done", int'(done), 0);
        chk("post_aborted", int'(aborted), 0);
        chk("post_busy", int'(busy), 0);
        chk("post_ready", int'(cfg_ready), 1);
        chk("post_cnt", int'(cnt_out), int'(e));
`ifdef UP_CNT_SEQ_PASS_IDX_EN
        chk("post_pass_idx", int'(pass_idx), int'(r));
`endif
    endtask

    typedef struct {
        logic [4:0] s;
        logic [4:0] e;
        logic [3:0] r;
        int         n;
        int         last;
    } vec_t;

    vec_t tbl[4];
    int   nv;
    int   lv;

    initial begin
        tbl[0] = '{s: 5'd0,  e: 5'd4,  r: 4'd0, n: 5,  last: 4};
        tbl[1] = '{s: 5'd30, e: 5'd1,  r: 4'd1, n: 8,  last: 1};
        tbl[2] = '{s: 5'd5,  e: 5'd5,  r: 4'd2, n: 3,  last: 5};
        tbl[3] = '{s: 5'd0,  e: 5'd31, r: 4'd0, n: 32, last: 31};

        reset     = 1'b1;
        cfg_valid = 1'b0;
        cfg_start = '0;
        cfg_end   = '0;
        cfg_reps  = '0;
        pause     = 1'b0;
        abort     = 1'b0;
        repeat (2) @(posedge clk);
        step();
        #1;
        chk("rst_cnt", int'(cnt_out), 0);
        chk("rst_valid", int'(cnt_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_aborted", int'(aborted), 0);
        chk("rst_ready", int'(cfg_ready), 1);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            sweep(tbl[i].s, tbl[i].e, tbl[i].r, 1'b0, -1, 0, 1'b0, nv, lv);
            chk("tbl_count", nv, tbl[i].n);
            chk("tbl_last", lv, tbl[i].last);
        end

        // pause for 3 cycles while showing 6
        sweep(5'd2, 5'd9, 4'd0, 1'b0, 6, 3, 1'b0, nv, lv);
        chk("pause_count", nv, 8);
        chk("pause_last", lv, 9);

        // abort at 10, then an immediate new descriptor
        step();
        cfg_valid = 1'b1;
        cfg_start = 5'd0;
        cfg_end   = 5'd20;
        cfg_reps  = 4'd0;
        step();
        cfg_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            #1;
            chk("ab_run_cnt", int'(cnt_out), i);
        end
        step();
        abort = 1'b1;
        #1;
        chk("ab_cnt10", int'(cnt_out), 10);
        chk("ab_valid", int'(cnt_valid), 0);
        step();
        abort     = 1'b0;
        cfg_valid = 1'b1;
        cfg_start = 5'd3;
        cfg_end   = 5'd4;
        #1;
        chk("ab_aborted", int'(aborted), 1);
        chk("ab_done", int'(done), 0);
        chk("ab_busy", int'(busy), 0);
        chk("ab_hold", int'(cnt_out), 10);
        chk("ab_ready", int'(cfg_ready), 1);
        step();
        cfg_valid = 1'b0;
        #1;
        chk("ab_new_load", int'(busy), 1);
        chk("ab_pulse_len", int'(aborted), 0);
        for (int i = 0; i < 2; i++) begin
            step();
            #1;
            chk("ab_new_cnt", int'(cnt_out), 3 + i);
            chk("ab_new_valid", int'(cnt_valid), 1);
        end
        step();
        #1;
        chk("ab_new_done", int'(done), 1);
        step();

        // reset at 12 with a descriptor held while busy
        step();
        cfg_valid = 1'b1;
        cfg_start = 5'd0;
        cfg_end   = 5'd20;
        cfg_reps  = 4'd0;
        step();
        cfg_start = 5'd7;
        cfg_end   = 5'd8;
        for (int i = 0; i < 12; i++) begin
            step();
            #1;
            chk("rs_run_cnt", int'(cnt_out), i);
            chk("rs_ready", int'(cfg_ready), 0);
        end
        step();
        #1;
        chk("rs_cnt12", int'(cnt_out), 12);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("rs_cnt", int'(cnt_out), 0);
        chk("rs_valid", int'(cnt_valid), 0);
        chk("rs_busy", int'(busy), 0);
        chk("rs_done", int'(done), 0);
        chk("rs_aborted", int'(aborted), 0);
        chk("rs_ready", int'(cfg_ready), 1);
        step();
        cfg_valid = 1'b0;
        #1;
        chk("rs_load", int'(busy), 1);
        chk("rs_no_pulse", int'(done | aborted), 0);
        for (int i = 0; i < 2; i++) begin
            step();
            #1;
            chk("rs_new_cnt", int'(cnt_out), 7 + i);
        end
        step();
        #1;
        chk("rs_new_done", int'(done), 1);
        step();

        for (int k = 0; k < 30; k++) begin
            logic [4:0] rs;
            logic [4:0] re;
            logic [3:0] rr;
            int         len;
            rs  = 5'($urandom_range(0, 31));
            re  = 5'($urandom_range(0, 31));
            rr  = 4'($urandom_range(0, 3));
            len = (int'(re) - int'(rs) + 32) % 32 + 1;
            sweep(rs, re, rr, 1'b1, -1, 0, 1'($urandom_range(0, 1)), nv, lv);
            chk("rnd_count", nv, (int'(rr) + 1) * len);
            chk("rnd_last", lv, int'(re));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
